// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file access arbiter.
package rf_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int unsigned RF_ADDR_WIDTH = 4;
    localparam int unsigned RF_DEPTH      = 1 << RF_ADDR_WIDTH;

    // Width of a round-robin index over n requesters (at least one bit).
    function automatic int unsigned rr_idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned rf_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Rotating-priority picker: up to two one-hot grants, scanning req from ptr.
module rr_pick2
    import rf_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = rr_idx_width(N)
) (
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt0,
    output logic [N-1:0]  gnt1,
    output logic [IW-1:0] idx0,
    output logic [IW-1:0] idx1,
    output logic          vld0,
    output logic          vld1
);

    int unsigned     cand;
    logic [IW-1:0]   cand_idx;

    always_comb begin
        gnt0     = '0;
        gnt1     = '0;
        idx0     = '0;
        idx1     = '0;
        vld0     = 1'b0;
        vld1     = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                if (!vld0) begin
                    vld0           = 1'b1;
                    idx0           = cand_idx;
                    gnt0[cand_idx] = 1'b1;
                end else if (!vld1) begin
                    vld1           = 1'b1;
                    idx1           = cand_idx;
                    gnt1[cand_idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing a 2R/1W register file; clears the file after reset.
// Optional macro RF_WR_BYPASS_EN forwards same-cycle write data to colliding reads.
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_RD     = 4,
    parameter int unsigned NUM_WR     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0]              rd_req_valid,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_req_addr,
    output logic [NUM_RD-1:0]              rd_req_ready,
    output logic [NUM_RD-1:0]              rd_rsp_valid,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_rsp_data,
    input  logic [NUM_WR-1:0]              wr_req_valid,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_req_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_req_data,
    output logic [NUM_WR-1:0]              wr_req_ready,
    output logic                           init_done,
    output logic                           rf_rd_req_0,
    output logic                           rf_rd_req_1,
    output logic [ADDR_WIDTH-1:0]          rf_rd_addr_0,
    output logic [ADDR_WIDTH-1:0]          rf_rd_addr_1,
    input  logic [DATA_WIDTH-1:0]          rf_rd_data_0,
    input  logic [DATA_WIDTH-1:0]          rf_rd_data_1,
    output logic                           rf_wr_req_0,
    output logic [ADDR_WIDTH-1:0]          rf_wr_addr_0,
    output logic [DATA_WIDTH-1:0]          rf_wr_data_0
);

    localparam int unsigned           RD_IW     = rr_idx_width(NUM_RD);
    localparam int unsigned           WR_IW     = rr_idx_width(NUM_WR);
    localparam int unsigned           DEPTH     = rf_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    arb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic                   init_done_q, init_done_d;
    logic [RD_IW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [WR_IW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [NUM_RD-1:0]      rsp_vld_q, rsp_vld_d;
    logic [NUM_RD-1:0]      rsp_port_q, rsp_port_d;

    logic                   run;
    logic [NUM_RD-1:0]      rd_gnt0, rd_gnt1;
    logic [RD_IW-1:0]       rd_idx0, rd_idx1;
    logic                   rd_vld0, rd_vld1;
    logic [NUM_WR-1:0]      wr_gnt0;
    logic [WR_IW-1:0]       wr_idx0;
    logic                   wr_vld0;
    logic [NUM_WR-1:0]      wr_gnt1_unused;
    logic [WR_IW-1:0]       wr_idx1_unused;
    logic                   wr_vld1_unused;
    logic [DATA_WIDTH-1:0]  port0_data, port1_data;

    assign run = (state_q == ST_RUN);

    rr_pick2 #(
        .N  (NUM_RD),
        .IW (RD_IW)
    ) u_rd_pick (
        .ptr  (rd_ptr_q),
        .req  (rd_req_valid),
        .gnt0 (rd_gnt0),
        .gnt1 (rd_gnt1),
        .idx0 (rd_idx0),
        .idx1 (rd_idx1),
        .vld0 (rd_vld0),
        .vld1 (rd_vld1)
    );

    rr_pick2 #(
        .N  (NUM_WR),
        .IW (WR_IW)
    ) u_wr_pick (
        .ptr  (wr_ptr_q),
        .req  (wr_req_valid),
        .gnt0 (wr_gnt0),
        .gnt1 (wr_gnt1_unused),
        .idx0 (wr_idx0),
        .idx1 (wr_idx1_unused),
        .vld0 (wr_vld0),
        .vld1 (wr_vld1_unused)
    );

    // Read grants, register-file read ports and the response steering map.
    always_comb begin
        rd_req_ready = '0;
        rf_rd_req_0  = 1'b0;
        rf_rd_req_1  = 1'b0;
        rf_rd_addr_0 = '0;
        rf_rd_addr_1 = '0;
        rsp_vld_d    = '0;
        rsp_port_d   = '0;
        rd_ptr_d     = rd_ptr_q;
        if (run) begin
            rd_req_ready = rd_gnt0 | rd_gnt1;
            rf_rd_req_0  = rd_vld0;
            rf_rd_req_1  = rd_vld1;
            rsp_vld_d    = rd_gnt0 | rd_gnt1;
            rsp_port_d   = rd_gnt1;
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (rd_gnt0[i]) begin
                    rf_rd_addr_0 = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
                if (rd_gnt1[i]) begin
                    rf_rd_addr_1 = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
            if (rd_vld1) begin
                rd_ptr_d = (rd_idx1 == RD_IW'(NUM_RD - 1)) ? '0 : rd_idx1 + 1'b1;
            end else if (rd_vld0) begin
                rd_ptr_d = (rd_idx0 == RD_IW'(NUM_RD - 1)) ? '0 : rd_idx0 + 1'b1;
            end
        end
    end

    // Write port: the clear sweep owns it in INIT, the write arbiter in RUN.
    always_comb begin
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
        init_done_d  = init_done_q;
        wr_ptr_d     = wr_ptr_q;
        wr_req_ready = '0;
        rf_wr_req_0  = 1'b0;
        rf_wr_addr_0 = '0;
        rf_wr_data_0 = '0;
        if (state_q == ST_INIT) begin
            // The reset term keeps the sweep write quiet while reset is held.
            rf_wr_req_0  = ~reset;
            rf_wr_addr_0 = sweep_cnt_q;
            sweep_cnt_d  = sweep_cnt_q + 1'b1;
            if (sweep_cnt_q == LAST_ADDR) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end else begin
            wr_req_ready = wr_gnt0;
            rf_wr_req_0  = wr_vld0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_gnt0[j]) begin
                    rf_wr_addr_0 = wr_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                    rf_wr_data_0 = wr_req_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (wr_vld0) begin
                wr_ptr_d = (wr_idx0 == WR_IW'(NUM_WR - 1)) ? '0 : wr_idx0 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
            init_done_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rsp_vld_q   <= '0;
            rsp_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            init_done_q <= init_done_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_port_q  <= rsp_port_d;
        end
    end

`ifdef RF_WR_BYPASS_EN
    logic [1:0]            byp_hit_q, byp_hit_d;
    logic [DATA_WIDTH-1:0] byp_data0_q, byp_data0_d;
    logic [DATA_WIDTH-1:0] byp_data1_q, byp_data1_d;

    always_comb begin
        byp_hit_d[0] = rf_rd_req_0 & rf_wr_req_0 & (rf_rd_addr_0 == rf_wr_addr_0);
        byp_hit_d[1] = rf_rd_req_1 & rf_wr_req_0 & (rf_rd_addr_1 == rf_wr_addr_0);
        byp_data0_d  = rf_wr_data_0;
        byp_data1_d  = rf_wr_data_0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_hit_q   <= '0;
            byp_data0_q <= '0;
            byp_data1_q <= '0;
        end else begin
            byp_hit_q   <= byp_hit_d;
            byp_data0_q <= byp_data0_d;
            byp_data1_q <= byp_data1_d;
        end
    end

    assign port0_data = byp_hit_q[0] ? byp_data0_q : rf_rd_data_0;
    assign port1_data = byp_hit_q[1] ? byp_data1_q : rf_rd_data_1;
`else
    assign port0_data = rf_rd_data_0;
    assign port1_data = rf_rd_data_1;
`endif

    always_comb begin
        rd_rsp_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rsp_vld_q[i]) begin
                rd_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rsp_port_q[i] ? port1_data : port0_data;
            end
        end
    end

    assign rd_rsp_valid = rsp_vld_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a small behavioural register file.
module tb_rf_access_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   rd_req_valid;
    logic [15:0]  rd_req_addr;
    logic [3:0]   rd_req_ready;
    logic [3:0]   rd_rsp_valid;
    logic [127:0] rd_rsp_data;
    logic [1:0]   wr_req_valid;
    logic [7:0]   wr_req_addr;
    logic [63:0]  wr_req_data;
    logic [1:0]   wr_req_ready;
    logic         init_done;
    logic         rf_rd_req_0, rf_rd_req_1;
    logic [3:0]   rf_rd_addr_0, rf_rd_addr_1;
    logic [31:0]  rf_rd_data_0, rf_rd_data_1;
    logic         rf_wr_req_0;
    logic [3:0]   rf_wr_addr_0;
    logic [31:0]  rf_wr_data_0;

    int total;
    int bad;

`ifdef RF_WR_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'h22;
`else
    localparam logic [31:0] COLL_EXP = 32'h11;
`endif

    rf_access_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .NUM_RD     (4),
        .NUM_WR     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_ready (rd_req_ready),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .wr_req_valid (wr_req_valid),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_ready (wr_req_ready),
        .init_done    (init_done),
        .rf_rd_req_0  (rf_rd_req_0),
        .rf_rd_req_1  (rf_rd_req_1),
        .rf_rd_addr_0 (rf_rd_addr_0),
        .rf_rd_addr_1 (rf_rd_addr_1),
        .rf_rd_data_0 (rf_rd_data_0),
        .rf_rd_data_1 (rf_rd_data_1),
        .rf_wr_req_0  (rf_wr_req_0),
        .rf_wr_addr_0 (rf_wr_addr_0),
        .rf_wr_data_0 (rf_wr_data_0)
    );

    // Register file: 1-cycle read latency, reads see the pre-write contents.
    logic [31:0] mem [16];
    logic        seed_mem;

    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else begin
            if (rf_rd_req_0) rf_rd_data_0 <= mem[rf_rd_addr_0];
            if (rf_rd_req_1) rf_rd_data_1 <= mem[rf_rd_addr_1];
            if (rf_wr_req_0) mem[rf_wr_addr_0] <= rf_wr_data_0;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   rd_valid;
        logic [15:0]  rd_addr;
        logic [1:0]   wr_valid;
        logic [7:0]   wr_addr;
        logic [63:0]  wr_data;
        logic [3:0]   exp_rd_ready;
        logic [1:0]   exp_wr_ready;
        logic [3:0]   exp_rsp_valid;
        logic [127:0] exp_rsp_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        seed_mem = 1'b1;
        rd_req_valid = '0;
        rd_req_addr  = '0;
        wr_req_valid = '0;
        wr_req_addr  = '0;
        wr_req_data  = '0;

        // rd_addr nibbles {a3,a2,a1,a0}; rsp data words {d3,d2,d1,d0}
        vecs[0] = '{4'b0000, 16'h0000, 2'b10, 8'h50, {32'hDEADBEEF, 32'h0},
                    4'b0000, 2'b10, 4'b0000, 128'h0};
        vecs[1] = '{4'b0100, 16'h0500, 2'b00, 8'h00, 64'h0,
                    4'b0100, 2'b00, 4'b0100, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
        vecs[2] = '{4'b1000, 16'h5000, 2'b00, 8'h00, 64'h0,
                    4'b1000, 2'b00, 4'b1000, {32'hDEADBEEF, 32'h0, 32'h0, 32'h0}};
        vecs[3] = '{4'b1111, 16'h5165, 2'b11, 8'h21, {32'h2222_0000, 32'h1111_0000},
                    4'b0011, 2'b01, 4'b0011, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}};
        vecs[4] = '{4'b1111, 16'h5121, 2'b11, 8'h24, {32'h2222_0000, 32'h4444_0000},
                    4'b1100, 2'b10, 4'b1100, {32'hDEADBEEF, 32'h1111_0000, 32'h0, 32'h0}};
        vecs[5] = '{4'b1111, 16'h4421, 2'b01, 8'h04, {32'h0, 32'h4444_0000},
                    4'b0011, 2'b01, 4'b0011, {32'h0, 32'h0, 32'h2222_0000, 32'h1111_0000}};
        vecs[6] = '{4'b1111, 16'h4450, 2'b00, 8'h00, 64'h0,
                    4'b1100, 2'b00, 4'b1100, {32'h4444_0000, 32'h4444_0000, 32'h0, 32'h0}};
        vecs[7] = '{4'b0011, 16'h0050, 2'b10, 8'h90, {32'h99, 32'h0},
                    4'b0011, 2'b10, 4'b0011, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[8] = '{4'b0000, 16'h0000, 2'b00, 8'h00, 64'h0,
                    4'b0000, 2'b00, 4'b0000, 128'h0};

        repeat (3) @(negedge clk);
        chk("reset rd_ready", rd_req_ready, 0);
        chk("reset wr_ready", wr_req_ready, 0);
        chk("reset rsp_valid", rd_rsp_valid, 0);
        chk("reset rf_wr_req", rf_wr_req_0, 0);
        chk("reset rf_rd_req", {rf_rd_req_1, rf_rd_req_0}, 0);
        chk("reset init_done", init_done, 0);

        seed_mem = 1'b0;
        reset    = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk($sformatf("sweep%0d wr_req", c), rf_wr_req_0, 1);
            chk($sformatf("sweep%0d wr_addr", c), rf_wr_addr_0, c);
            chk($sformatf("sweep%0d wr_data", c), rf_wr_data_0, 0);
            chk($sformatf("sweep%0d rd_ready", c), rd_req_ready, 0);
            chk($sformatf("sweep%0d init_done", c), init_done, 0);
            @(negedge clk);
        end
        #1;
        chk("init_done after sweep", init_done, 1);
        chk("idle rf_wr_req", rf_wr_req_0, 0);

        for (int v = 0; v < 9; v++) begin
            rd_req_valid = vecs[v].rd_valid;
            rd_req_addr  = vecs[v].rd_addr;
            wr_req_valid = vecs[v].wr_valid;
            wr_req_addr  = vecs[v].wr_addr;
            wr_req_data  = vecs[v].wr_data;
            #1;
            chk($sformatf("v%0d rd_ready", v), rd_req_ready, vecs[v].exp_rd_ready);
            chk($sformatf("v%0d wr_ready", v), wr_req_ready, vecs[v].exp_wr_ready);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rsp_valid", v), rd_rsp_valid, vecs[v].exp_rsp_valid);
            chk($sformatf("v%0d rsp_data", v), rd_rsp_data, vecs[v].exp_rsp_data);
            @(negedge clk);
        end

        chk("mem[1]", mem[1], 32'h1111_0000);
        chk("mem[2]", mem[2], 32'h2222_0000);
        chk("mem[4]", mem[4], 32'h4444_0000);
        chk("mem[5]", mem[5], 32'hDEADBEEF);
        chk("mem[9]", mem[9], 32'h99);
        chk("mem[7] swept", mem[7], 32'h0);

        // Collision: old value 0x11 at addr 3, then read and write 0x22 together.
        rd_req_valid = 4'b0000;
        rd_req_addr  = 16'h0000;
        wr_req_valid = 2'b01;
        wr_req_addr  = 8'h03;
        wr_req_data  = {32'h0, 32'h11};
        #1;
        chk("coll pre wr_ready", wr_req_ready, 2'b01);
        @(negedge clk);
        rd_req_valid = 4'b0001;
        rd_req_addr  = 16'h0003;
        wr_req_valid = 2'b10;
        wr_req_addr  = 8'h30;
        wr_req_data  = {32'h22, 32'h0};
        #1;
        chk("coll rd_ready", rd_req_ready, 4'b0001);
        chk("coll wr_ready", wr_req_ready, 2'b10);
        chk("coll rf_wr_addr", rf_wr_addr_0, 4'h3);
        @(posedge clk);
        #1;
        chk("coll rsp_valid", rd_rsp_valid, 4'b0001);
        chk("coll rsp_data", rd_rsp_data, {96'h0, COLL_EXP});
        @(negedge clk);
        wr_req_valid = 2'b00;
        chk("coll mem[3]", mem[3], 32'h22);

        // Reset right after a read handshake drops the pending response.
        rd_req_valid = 4'b0010;
        rd_req_addr  = 16'h0050;
        #1;
        chk("rst rd_ready", rd_req_ready, 4'b0010);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_req_valid = 4'b0000;
        @(negedge clk);
        chk("rst rsp_valid", rd_rsp_valid, 0);
        chk("rst rsp_data", rd_rsp_data, 0);
        chk("rst init_done", init_done, 0);
        chk("rst rf_wr_req", rf_wr_req_0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("resweep wr_req", rf_wr_req_0, 1);
        chk("resweep addr0", rf_wr_addr_0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("resweep addr1", rf_wr_addr_0, 1);
        chk("resweep rsp_valid", rd_rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
